ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/ram_arbiter.sv | 92 +++++++++
 tb/tb_ram_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// The arbiter uses the slave modport; requesters and the RAM model use master.
interface ram_arbiter_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 5
);
  logic                 REQ_A, REQ_B;
  logic                 WE_A, WE_B;
  logic [ADDR_BITS-1:0] ADDR_A, ADDR_B;
  logic [DATA_BITS-1:0] WDATA_A, WDATA_B;
  logic                 ACK_A, ACK_B;
  logic [DATA_BITS-1:0] RDATA_A, RDATA_B;
  logic                 BUSY;
  logic                 GRANT;
  logic [ADDR_BITS-1:0] RAM_ADDR;
  logic [DATA_BITS-1:0] RAM_DATA_IN;
  logic                 RAM_WRITE;
  logic [DATA_BITS-1:0] RAM_DATA_OUT;

  modport slave (
    input  REQ_A, REQ_B, WE_A, WE_B, ADDR_A, ADDR_B, WDATA_A, WDATA_B, RAM_DATA_OUT,
    output ACK_A, ACK_B, RDATA_A, RDATA_B, BUSY, GRANT, RAM_ADDR, RAM_DATA_IN, RAM_WRITE
  );

  modport master (
    output REQ_A, REQ_B, WE_A, WE_B, ADDR_A, ADDR_B, WDATA_A, WDATA_B, RAM_DATA_OUT,
    input  ACK_A, ACK_B, RDATA_A, RDATA_B, BUSY, GRANT, RAM_ADDR, RAM_DATA_IN, RAM_WRITE
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a single-port RAM with registered read data.
// Every transaction takes IDLE -> ACCESS -> WAIT -> DONE, so ACK lands 3 cycles after grant.
module ram_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 grant_q, grant_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_BITS-1:0] rdata_b_q, rdata_b_d;
  logic                 winner;

  // 0 = A, 1 = B; prio only matters on a tie
  assign winner = (bus.REQ_A && bus.REQ_B) ? prio_q : bus.REQ_B;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    case (state_q)
      IDLE: begin
        if (bus.REQ_A || bus.REQ_B) begin
          state_d = ACCESS;
          grant_d = winner;
          prio_d  = ~winner;
          we_d    = winner ? bus.WE_B    : bus.WE_A;
          addr_d  = winner ? bus.ADDR_B  : bus.ADDR_A;
          wdata_d = winner ? bus.WDATA_B : bus.WDATA_A;
        end
      end
      ACCESS: state_d = WAIT;
      WAIT: begin
        state_d = DONE;
        // RAM_DATA_OUT now holds the word addressed during ACCESS
        if (!we_q) begin
          if (grant_q) rdata_b_d = bus.RAM_DATA_OUT;
          else         rdata_a_d = bus.RAM_DATA_OUT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Outputs decode straight from flops so reset clears them asynchronously
  assign bus.ACK_A       = (state_q == DONE) && !grant_q;
  assign bus.ACK_B       = (state_q == DONE) &&  grant_q;
  assign bus.BUSY        = (state_q != IDLE);
  assign bus.GRANT       = grant_q;
  assign bus.RAM_WRITE   = (state_q == ACCESS) && we_q;
  assign bus.RAM_ADDR    = addr_q;
  assign bus.RAM_DATA_IN = wdata_q;
  assign bus.RDATA_A     = rdata_a_q;
  assign bus.RDATA_B     = rdata_b_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model compared every cycle, directed
// scenarios with literal expectations, then randomized two-requester traffic.
module tb_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();
  ram_arbiter #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Single-port RAM with registered read
  logic [DW-1:0] ram [0:31] = '{default: '0};
  always @(posedge clk) begin
    if (bus.RAM_WRITE) ram[bus.RAM_ADDR] <= bus.RAM_DATA_IN;
    bus.RAM_DATA_OUT <= ram[bus.RAM_ADDR];
  end
  initial bus.RAM_DATA_OUT = '0;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: m_cnt = cycles since grant (0 = no transaction in flight)
  int            m_cnt;
  logic          m_grant, m_prio, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rda, m_rdb;
  logic [DW-1:0] mdl_mem [0:31] = '{default: '0};
  logic          m_win;

  assign m_win = (bus.REQ_A && bus.REQ_B) ? m_prio : bus.REQ_B;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_grant <= 1'b0; m_prio <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rda <= '0; m_rdb <= '0;
    end else if (m_cnt == 0) begin
      if (bus.REQ_A || bus.REQ_B) begin
        m_cnt   <= 1;
        m_grant <= m_win;
        m_prio  <= !m_win;
        m_we    <= m_win ? bus.WE_B    : bus.WE_A;
        m_addr  <= m_win ? bus.ADDR_B  : bus.ADDR_A;
        m_wdata <= m_win ? bus.WDATA_B : bus.WDATA_A;
      end
    end else begin
      m_cnt <= (m_cnt + 1) % 4;
      if (m_cnt == 1 && m_we) mdl_mem[m_addr] <= m_wdata;
      if (m_cnt == 2 && !m_we) begin
        if (m_grant) m_rdb <= mdl_mem[m_addr];
        else         m_rda <= mdl_mem[m_addr];
      end
    end
  end

  // Per-cycle compare of every DUT output against the model
  always @(negedge clk) begin
    chk("ack_a",    bus.ACK_A,       (m_cnt == 3) && !m_grant);
    chk("ack_b",    bus.ACK_B,       (m_cnt == 3) &&  m_grant);
    chk("ack_excl", bus.ACK_A & bus.ACK_B, 1'b0);
    chk("busy",     bus.BUSY,        m_cnt != 0);
    chk("grant",    bus.GRANT,       m_grant);
    chk("ram_wr",   bus.RAM_WRITE,   (m_cnt == 1) && m_we);
    chk("ram_addr", bus.RAM_ADDR,    m_addr);
    chk("ram_din",  bus.RAM_DATA_IN, m_wdata);
    chk("rdata_a",  bus.RDATA_A,     m_rda);
    chk("rdata_b",  bus.RDATA_B,     m_rdb);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic who, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!who) begin bus.REQ_A = req; bus.WE_A = we; bus.ADDR_A = a; bus.WDATA_A = d; end
    else      begin bus.REQ_B = req; bus.WE_B = we; bus.ADDR_B = a; bus.WDATA_B = d; end
  endtask

  // Full transaction obeying the requester contract; returns in the next IDLE cycle
  task automatic run_txn(input logic who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_req(who, 1'b1, we, a, d);
    repeat (4) tick;
    set_req(who, 1'b0, 1'b0, '0, '0);
  endtask

  logic ack_a_prev, ack_b_prev;

  initial begin
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) tick;
    chk("rst_busy",  bus.BUSY,      1'b0);
    chk("rst_grant", bus.GRANT,     1'b0);
    chk("rst_raddr", bus.RAM_ADDR,  0);
    chk("rst_rda",   bus.RDATA_A,   0);
    chk("rst_rdb",   bus.RDATA_B,   0);
    rst_n = 1'b1;

    // A writes A5 to 3
    set_req(1'b0, 1'b1, 1'b1, 5'd3, 8'hA5);
    tick;
    chk("w3_ramwr",  bus.RAM_WRITE,   1'b1);
    chk("w3_addr",   bus.RAM_ADDR,    3);
    chk("w3_din",    bus.RAM_DATA_IN, 8'hA5);
    tick;
    chk("w3_wr_off", bus.RAM_WRITE,   1'b0);
    chk("w3_noack",  bus.ACK_A,       1'b0);
    tick;
    chk("w3_ack",    bus.ACK_A,       1'b1);
    tick;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);

    // B reads 3 back
    set_req(1'b1, 1'b1, 1'b0, 5'd3, '0);
    repeat (3) tick;
    chk("r3_ack",    bus.ACK_B,   1'b1);
    chk("r3_data",   bus.RDATA_B, 8'hA5);
    chk("r3_rda",    bus.RDATA_A, 0);
    tick;
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    run_txn(1'b0, 1'b1, 5'd30, 8'h3C);
    run_txn(1'b1, 1'b1, 5'd31, 8'hC3);

    // Both requesting out of reset: A then B, 4 cycles apart
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 5'd30, '0);
    set_req(1'b1, 1'b1, 1'b0, 5'd31, '0);
    tick;
    chk("rr_rst_busy", bus.BUSY, 1'b0);
    rst_n = 1'b1;
    tick;
    chk("rr_g0",    bus.GRANT,   1'b0);
    repeat (2) tick;
    chk("rr_acka",  bus.ACK_A,   1'b1);
    chk("rr_rda",   bus.RDATA_A, 8'h3C);
    chk("rr_nackb", bus.ACK_B,   1'b0);
    tick;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    chk("rr_idle",  bus.BUSY,    1'b0);
    tick;
    chk("rr_g1",    bus.GRANT,   1'b1);
    repeat (2) tick;
    chk("rr_ackb",  bus.ACK_B,   1'b1);
    chk("rr_rdb",   bus.RDATA_B, 8'hC3);
    tick;
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    // Both held for 8 transactions: strict alternation starting with A
    set_req(1'b0, 1'b1, 1'b1, 5'd7, 8'h5A);
    set_req(1'b1, 1'b1, 1'b0, 5'd7, '0);
    for (int k = 0; k < 8; k++) begin
      repeat (3) tick;
      chk("alt_acka", bus.ACK_A, (k % 2) == 0);
      chk("alt_ackb", bus.ACK_B, (k % 2) == 1);
      if (k % 2 == 1) chk("alt_rdb", bus.RDATA_B, 8'h5A);
      tick;
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    // Address change after latching is ignored
    set_req(1'b0, 1'b1, 1'b1, 5'd5, 8'h11);
    tick;
    bus.ADDR_A = 5'd9; bus.WDATA_A = 8'hEE;
    #1;
    chk("hold_addr", bus.RAM_ADDR,    5);
    chk("hold_din",  bus.RAM_DATA_IN, 8'h11);
    tick;
    chk("hold_addr2", bus.RAM_ADDR,   5);
    tick;
    chk("hold_ack",  bus.ACK_A,       1'b1);
    tick;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b1, 1'b0, 5'd5, '0);
    repeat (3) tick;
    chk("hold_rd5",  bus.RDATA_B,     8'h11);
    tick;
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset during ACCESS of a write to 31 aborts it
    set_req(1'b0, 1'b1, 1'b1, 5'd31, 8'h77);
    tick;
    chk("ab_wr_on",  bus.RAM_WRITE, 1'b1);
    chk("ab_addr",   bus.RAM_ADDR,  31);
    #1 rst_n = 1'b0;
    #1;
    chk("ab_wr_off", bus.RAM_WRITE, 1'b0);
    chk("ab_busy",   bus.BUSY,      1'b0);
    chk("ab_addr0",  bus.RAM_ADDR,  0);
    chk("ab_noack",  bus.ACK_A,     1'b0);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("ab_noack2", bus.ACK_A,     1'b0);
    set_req(1'b0, 1'b1, 1'b0, 5'd31, '0);
    set_req(1'b1, 1'b1, 1'b0, 5'd0, '0);
    tick;
    chk("ab_prio_a", bus.GRANT,     1'b0);
    repeat (2) tick;
    chk("ab_ack_a",  bus.ACK_A,     1'b1);
    chk("ab_old31",  bus.RDATA_A,   8'hC3);
    tick;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (4) tick;
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    // Randomized traffic, mostly contract-abiding with occasional early drops
    ack_a_prev = 1'b0;
    ack_b_prev = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (ack_a_prev) bus.REQ_A = 1'b0;
      else if (!bus.REQ_A && $urandom_range(0, 2) == 0)
        set_req(1'b0, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
      else if (bus.REQ_A && $urandom_range(0, 29) == 0) bus.REQ_A = 1'b0;
      else if (bus.REQ_A && $urandom_range(0, 9) == 0) bus.ADDR_A = AW'($urandom);
      if (ack_b_prev) bus.REQ_B = 1'b0;
      else if (!bus.REQ_B && $urandom_range(0, 2) == 0)
        set_req(1'b1, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
      else if (bus.REQ_B && $urandom_range(0, 29) == 0) bus.REQ_B = 1'b0;
      else if (bus.REQ_B && $urandom_range(0, 9) == 0) bus.WDATA_B = DW'($urandom);
      ack_a_prev = bus.ACK_A;
      ack_b_prev = bus.ACK_B;
      tick;
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (6) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
